// File: rtl/hp_drain_sched_pkg.sv
// rtl/hp_drain_sched_pkg.sv - shared state encoding, register indices and widths for hp_drain_sched
package hp_drain_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_READ   = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam logic [1:0] R1_IDX = 2'd0;
  localparam logic [1:0] R2_IDX = 2'd1;
  localparam logic [1:0] R3_IDX = 2'd2;
  localparam logic [1:0] R4_IDX = 2'd3;

  localparam int COUNT_W = 16;

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [1:0] rr_ptr_next(input logic [1:0] idx);
    return (idx == R3_IDX) ? R1_IDX : idx + 2'd1;
  endfunction

endpackage

// File: rtl/hp_drain_sched_if.sv
// rtl/hp_drain_sched_if.sv - downstream byte stream (valid/ready) carrying register-tagged bytes
interface hp_drain_sched_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_reg;
  logic       out_last;

  modport master (output out_valid, output out_data, output out_reg, output out_last,
                  input  out_ready);
  modport slave  (input  out_valid, input  out_data, input  out_reg, input  out_last,
                  output out_ready);
endinterface

// File: rtl/hp_drain_sched_arb.sv
// rtl/hp_drain_sched_arb.sv - hp_rr_arb3: combinational 3-way round-robin picker for R1-R3
module hp_rr_arb3 (
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_grant,
  output logic       o_valid
);

  always_comb begin
    o_grant = 3'b000;
    case (i_ptr)
      2'd1: begin
        if (i_req[1])      o_grant = 3'b010;
        else if (i_req[2]) o_grant = 3'b100;
        else if (i_req[0]) o_grant = 3'b001;
      end
      2'd2: begin
        if (i_req[2])      o_grant = 3'b100;
        else if (i_req[0]) o_grant = 3'b001;
        else if (i_req[1]) o_grant = 3'b010;
      end
      default: begin
        if (i_req[0])      o_grant = 3'b001;
        else if (i_req[1]) o_grant = 3'b010;
        else if (i_req[2]) o_grant = 3'b100;
      end
    endcase
    o_valid = |i_req;
  end

endmodule

// File: rtl/hp_drain_sched.sv
// rtl/hp_drain_sched.sv - drains host-to-parasite FIFOs R1-R4 onto a tagged byte stream
// Optional per-register read counters when HP_DRAIN_STATS_EN is defined.
module hp_drain_sched
  import hp_drain_sched_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter bit R4_PRIORITY   = 1'b1
) (
  input  logic                 p_phi2,
  input  logic                 p_rst,
  input  logic [3:0]           p_enable,
  input  logic [3:0]           p_data_available,
  input  logic                 p_r3_two_bytes_available,
  input  logic                 one_byte_mode,
  input  logic [7:0]           p_data,
  output logic [3:0]           p_selectData,
  output logic                 p_rdnw,
  output logic                 p_rd_en,
  output logic                 busy,
`ifdef HP_DRAIN_STATS_EN
  input  logic                 stats_clr,
  output logic [4*COUNT_W-1:0] drain_count,
`endif
  hp_drain_sched_if.master     out_if
);

  localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [1:0] r_grant;
  logic [1:0] r_ptr;
  logic [1:0] r_settle;
  logic       r_pair;
  logic       r_second;
  logic       r_r4_turn;
  logic [7:0] r_data;
  logic       r_last;

  logic [3:0] w_req;
  logic [2:0] w_rr_grant;
  logic       w_rr_valid;
  logic       w_r4_wins;
  logic [1:0] w_grant_idx;
  logic       w_pair_mid;

  // R3 only qualifies in pair mode once both bytes are present, so the pair never stalls halfway.
  always_comb begin
    w_req    = p_data_available & p_enable;
    w_req[2] = w_req[2] & (one_byte_mode | p_r3_two_bytes_available);
  end

  hp_rr_arb3 u_arb (
    .i_req   (w_req[2:0]),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_valid (w_rr_valid)
  );

  // Without fixed priority R4 takes a turn after every completed R1-R3 grant.
  assign w_r4_wins   = w_req[3] & (R4_PRIORITY | r_r4_turn | ~w_rr_valid);
  assign w_grant_idx = w_r4_wins     ? R4_IDX :
                       w_rr_grant[1] ? R2_IDX :
                       w_rr_grant[2] ? R3_IDX : R1_IDX;
  assign w_pair_mid  = r_pair & ~r_second;

  always_ff @(posedge p_phi2 or posedge p_rst) begin
    if (p_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    p_selectData = 4'b0000;
    p_rd_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) w_state_nxt = ST_SELECT;
      end
      ST_SELECT: begin
        p_selectData = idx_to_onehot(r_grant);
        if (r_settle == SETTLE_LAST) w_state_nxt = ST_READ;
      end
      ST_READ: begin
        p_selectData = idx_to_onehot(r_grant);
        p_rd_en      = 1'b1;
        w_state_nxt  = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_if.out_ready) w_state_nxt = w_pair_mid ? ST_SELECT : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge p_phi2 or posedge p_rst) begin
    if (p_rst) begin
      r_grant   <= R1_IDX;
      r_ptr     <= R1_IDX;
      r_settle  <= 2'd0;
      r_pair    <= 1'b0;
      r_second  <= 1'b0;
      r_r4_turn <= 1'b0;
      r_data    <= 8'h00;
      r_last    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_grant  <= w_grant_idx;
            r_settle <= 2'd0;
            r_second <= 1'b0;
            r_pair   <= (w_grant_idx == R3_IDX) & ~one_byte_mode;
          end
        end
        ST_SELECT: r_settle <= r_settle + 2'd1;
        ST_READ: begin
          r_data <= p_data;
          r_last <= ~w_pair_mid;
        end
        ST_HOLD: begin
          if (out_if.out_ready) begin
            if (w_pair_mid) begin
              r_second <= 1'b1;
              r_settle <= 2'd0;
            end else if (r_grant != R4_IDX) begin
              r_ptr     <= rr_ptr_next(r_grant);
              r_r4_turn <= 1'b1;
            end else begin
              r_r4_turn <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign p_rdnw           = 1'b1;
  assign busy             = (r_state != ST_IDLE);
  assign out_if.out_valid = (r_state == ST_HOLD);
  assign out_if.out_data  = r_data;
  assign out_if.out_reg   = r_grant;
  assign out_if.out_last  = r_last;

`ifdef HP_DRAIN_STATS_EN
  logic [COUNT_W-1:0] r_cnt [4];

  always_ff @(posedge p_phi2 or posedge p_rst) begin
    if (p_rst) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (stats_clr) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (p_rd_en && (r_cnt[r_grant] != {COUNT_W{1'b1}})) begin
      r_cnt[r_grant] <= r_cnt[r_grant] + 1'b1;
    end
  end

  assign drain_count = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
`endif

endmodule

// File: tb/tb_hp_drain_sched.sv
// tb/tb_hp_drain_sched.sv - scoreboard bench for hp_drain_sched (SETTLE_CYCLES=1, R4_PRIORITY=1)
module tb_hp_drain_sched;
  import hp_drain_sched_pkg::*;

  typedef struct packed {
    logic [1:0] r;
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] enable;
  logic [3:0] avail;
  logic       two;
  logic       obm;
  logic [7:0] p_data;
  logic [3:0] sel;
  logic       rdnw;
  logic       rd_en;
  logic       busy;
`ifdef HP_DRAIN_STATS_EN
  logic         stats_clr = 1'b0;
  logic [63:0]  drain_count;
`endif

  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] mem [4][8];
  int         rdidx [4];
  int         rd_total = 0;

  always #5 clk = ~clk;

  hp_drain_sched_if u_if ();

  hp_drain_sched #(.SETTLE_CYCLES(1), .R4_PRIORITY(1'b1)) dut (
    .p_phi2                   (clk),
    .p_rst                    (rst),
    .p_enable                 (enable),
    .p_data_available         (avail),
    .p_r3_two_bytes_available (two),
    .one_byte_mode            (obm),
    .p_data                   (p_data),
    .p_selectData             (sel),
    .p_rdnw                   (rdnw),
    .p_rd_en                  (rd_en),
    .busy                     (busy),
`ifdef HP_DRAIN_STATS_EN
    .stats_clr                (stats_clr),
    .drain_count              (drain_count),
`endif
    .out_if                   (u_if.master)
  );

  function automatic int sel_idx(input logic [3:0] s);
    case (s)
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t mk(input logic [1:0] r, input logic [7:0] d, input logic l);
    exp_t e;
    e.r = r; e.d = d; e.l = l;
    return e;
  endfunction

  // FIFO model: each register serves successive bytes of mem, advancing on its read pulse.
  always_comb p_data = mem[sel_idx(sel)][rdidx[sel_idx(sel)] % 8];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) rdidx[i] <= 0;
    end else if (rd_en) begin
      rdidx[sel_idx(sel)] <= rdidx[sel_idx(sel)] + 1;
    end
  end

  always @(negedge clk) if (rd_en) rd_total++;

  task automatic do_reset();
    rst = 1'b1; avail = 4'h0; enable = 4'hF; obm = 1'b1; two = 1'b0;
    u_if.out_ready = 1'b1;
    sb.delete();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 8; i++) mem[r][i] = 8'(8'h40 + 16 * r + i);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t got;
    rst = 1'b1; avail = 4'h0; enable = 4'hF; obm = 1'b1; two = 1'b0; u_if.out_ready = 1'b1;
    #1;
    got = mk(u_if.out_reg, u_if.out_data, u_if.out_last);
    n_vec++; if (sel !== 4'b0000) begin n_err++; $display("FAIL reset_sel got=%b want=0000", sel); end
    n_vec++; if (rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got=%b want=0", rd_en); end
    n_vec++; if (rdnw !== 1'b1) begin n_err++; $display("FAIL reset_rdnw got=%b want=1", rdnw); end
    n_vec++; if (u_if.out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL reset_valid_busy got=%b%b want=00", u_if.out_valid, busy); end
    n_vec++; if (got !== mk(2'd0, 8'h00, 1'b0)) begin
      n_err++; $display("FAIL reset_out got=%h want=%h", got, mk(2'd0, 8'h00, 1'b0)); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    int sel_cnt = 0, beats = 0, beat_c = -1, base;
    exp_t e, got;
    do_reset();
    mem[0][0] = 8'h5A;
    sb.push_back(mk(R1_IDX, 8'h5A, 1'b1));
    base = rd_total;
    avail = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (sel == 4'b0001) sel_cnt++;
      if (u_if.out_valid && u_if.out_ready) begin
        got = mk(u_if.out_reg, u_if.out_data, u_if.out_last);
        e = (sb.size() > 0) ? sb.pop_front() : mk(2'd0, 8'h00, 1'b0);
        n_vec++; if (got !== e) begin n_err++; $display("FAIL single_beat got=%h want=%h", got, e); end
        if (beat_c < 0) beat_c = c;
        beats++;
        avail = 4'b0000;
      end
    end
    n_vec++; if (beats != 1) begin n_err++; $display("FAIL single_beats got=%0d want=1", beats); end
    n_vec++; if (beat_c != 2) begin n_err++; $display("FAIL single_latency got=%0d want=2", beat_c); end
    n_vec++; if (sel_cnt != 2) begin n_err++; $display("FAIL single_sel_cycles got=%0d want=2", sel_cnt); end
    n_vec++; if (rd_total - base != 1) begin n_err++; $display("FAIL single_rd_pulses got=%0d want=1", rd_total - base); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_r4_priority();
    int beats = 0;
    exp_t e, got;
    do_reset();
    sb.push_back(mk(R4_IDX, mem[3][0], 1'b1));
    sb.push_back(mk(R4_IDX, mem[3][1], 1'b1));
    sb.push_back(mk(R4_IDX, mem[3][2], 1'b1));
    sb.push_back(mk(R1_IDX, mem[0][0], 1'b1));
    sb.push_back(mk(R2_IDX, mem[1][0], 1'b1));
    sb.push_back(mk(R3_IDX, mem[2][0], 1'b1));
    sb.push_back(mk(R1_IDX, mem[0][1], 1'b1));
    avail = 4'b1111;
    for (int c = 0; c < 200 && beats < 7; c++) begin
      @(negedge clk);
      if (u_if.out_valid && u_if.out_ready) begin
        got = mk(u_if.out_reg, u_if.out_data, u_if.out_last);
        e = (sb.size() > 0) ? sb.pop_front() : mk(2'd0, 8'h00, 1'b0);
        n_vec++; if (got !== e) begin n_err++; $display("FAIL r4_prio_beat%0d got=%h want=%h", beats, got, e); end
        beats++;
        if (beats == 3) avail = 4'b0111;
        if (beats == 7) avail = 4'b0000;
      end
    end
    n_vec++; if (beats != 7) begin n_err++; $display("FAIL r4_prio_beats got=%0d want=7", beats); end
  endtask

  task automatic test_r3_pair();
    int beats = 0, bad_sel = 0;
    exp_t e, got;
    do_reset();
    obm = 1'b0; two = 1'b1;
    mem[2][0] = 8'h11; mem[2][1] = 8'h22;
    sb.push_back(mk(R3_IDX, 8'h11, 1'b0));
    sb.push_back(mk(R3_IDX, 8'h22, 1'b1));
    sb.push_back(mk(R1_IDX, mem[0][0], 1'b1));
    avail = 4'b0100;
    for (int c = 0; c < 100 && beats < 3; c++) begin
      @(negedge clk);
      if (beats == 1 && sel != 4'b0000 && sel != 4'b0100) bad_sel++;
      if (u_if.out_valid && u_if.out_ready) begin
        got = mk(u_if.out_reg, u_if.out_data, u_if.out_last);
        e = (sb.size() > 0) ? sb.pop_front() : mk(2'd0, 8'h00, 1'b0);
        n_vec++; if (got !== e) begin n_err++; $display("FAIL r3_pair_beat%0d got=%h want=%h", beats, got, e); end
        beats++;
        if (beats == 1) begin avail = 4'b0001; two = 1'b0; end
        if (beats == 3) avail = 4'b0000;
      end
    end
    n_vec++; if (beats != 3) begin n_err++; $display("FAIL r3_pair_beats got=%0d want=3", beats); end
    n_vec++; if (bad_sel != 0) begin n_err++; $display("FAIL r3_pair_interleave got=%0d want=0", bad_sel); end
  endtask

  task automatic test_r3_withheld();
    int stray = 0, beats = 0, base;
    exp_t e, got;
    do_reset();
    obm = 1'b0; two = 1'b0;
    base = rd_total;
    avail = 4'b0100;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || sel !== 4'b0000) stray++;
    end
    n_vec++; if (stray != 0 || rd_total != base) begin
      n_err++; $display("FAIL r3_withheld_idle got=%0d/%0d want=0/0", stray, rd_total - base); end
    sb.push_back(mk(R3_IDX, mem[2][0], 1'b1));
    obm = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (u_if.out_valid && u_if.out_ready) begin
        got = mk(u_if.out_reg, u_if.out_data, u_if.out_last);
        e = (sb.size() > 0) ? sb.pop_front() : mk(2'd0, 8'h00, 1'b0);
        n_vec++; if (got !== e) begin n_err++; $display("FAIL r3_single_beat got=%h want=%h", got, e); end
        beats++;
        avail = 4'b0000;
      end
    end
    n_vec++; if (beats != 1 || rd_total - base != 1) begin
      n_err++; $display("FAIL r3_single_count got=%0d/%0d want=1/1", beats, rd_total - base); end
  endtask

  task automatic test_backpressure();
    int found = 0, unstable = 0, base;
    exp_t e, got;
    do_reset();
    u_if.out_ready = 1'b0;
    mem[0][0] = 8'hC3;
    sb.push_back(mk(R1_IDX, 8'hC3, 1'b1));
    avail = 4'b0001;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk);
      if (u_if.out_valid) found = 1;
    end
    n_vec++; if (found != 1) begin n_err++; $display("FAIL bp_valid_timeout got=0 want=1"); end
    base = rd_total;
    repeat (9) begin
      @(negedge clk);
      if (u_if.out_valid !== 1'b1 || u_if.out_data !== 8'hC3 || u_if.out_reg !== R1_IDX) unstable++;
    end
    n_vec++; if (unstable != 0 || rd_total != base) begin
      n_err++; $display("FAIL bp_stable got=%0d/%0d want=0/0", unstable, rd_total - base); end
    @(negedge clk);
    u_if.out_ready = 1'b1;
    got = mk(u_if.out_reg, u_if.out_data, u_if.out_last);
    e = (sb.size() > 0) ? sb.pop_front() : mk(2'd0, 8'h00, 1'b0);
    n_vec++; if (!u_if.out_valid || got !== e) begin
      n_err++; $display("FAIL bp_accept got=%b:%h want=1:%h", u_if.out_valid, got, e); end
    avail = 4'b0000;
    @(negedge clk);
    n_vec++; if (u_if.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_after got=%b want=0", u_if.out_valid); end
  endtask

  task automatic test_back_to_back();
    int beats = 0, rd1 = -1, rd2 = -1;
    exp_t e, got;
    do_reset();
    sb.push_back(mk(R1_IDX, mem[0][0], 1'b1));
    sb.push_back(mk(R1_IDX, mem[0][1], 1'b1));
    avail = 4'b0001;
    for (int c = 0; c < 30 && beats < 2; c++) begin
      @(negedge clk);
      if (rd_en) begin if (rd1 < 0) rd1 = c; else if (rd2 < 0) rd2 = c; end
      if (u_if.out_valid && u_if.out_ready) begin
        got = mk(u_if.out_reg, u_if.out_data, u_if.out_last);
        e = (sb.size() > 0) ? sb.pop_front() : mk(2'd0, 8'h00, 1'b0);
        n_vec++; if (got !== e) begin n_err++; $display("FAIL b2b_beat%0d got=%h want=%h", beats, got, e); end
        beats++;
        if (beats == 2) avail = 4'b0000;
      end
    end
    n_vec++; if (rd2 - rd1 != 4) begin n_err++; $display("FAIL b2b_spacing got=%0d want=4", rd2 - rd1); end
  endtask

  task automatic test_reset_mid_read();
    int beats = 0, hit = 0;
    exp_t e, got;
    do_reset();
    sb.push_back(mk(R1_IDX, mem[0][0], 1'b1));
    avail = 4'b0001;
    for (int c = 0; c < 20 && beats < 1; c++) begin
      @(negedge clk);
      if (u_if.out_valid && u_if.out_ready) begin
        got = mk(u_if.out_reg, u_if.out_data, u_if.out_last);
        e = (sb.size() > 0) ? sb.pop_front() : mk(2'd0, 8'h00, 1'b0);
        n_vec++; if (got !== e) begin n_err++; $display("FAIL rst_pre_beat got=%h want=%h", got, e); end
        beats++;
        avail = 4'b0000;
      end
    end
    @(negedge clk);
    avail = 4'b0011;
    for (int c = 0; c < 20 && hit == 0; c++) begin
      @(negedge clk);
      if (rd_en) hit = 1;
    end
    n_vec++; if (hit != 1) begin n_err++; $display("FAIL rst_read_timeout got=0 want=1"); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if ({sel, rd_en, u_if.out_valid, busy, rdnw} !== 8'b0000_0001) begin
      n_err++; $display("FAIL rst_mid_read got=%b want=00000001", {sel, rd_en, u_if.out_valid, busy, rdnw}); end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    sb.push_back(mk(R1_IDX, mem[0][0], 1'b1));
    beats = 0;
    for (int c = 0; c < 20 && beats < 1; c++) begin
      @(negedge clk);
      if (u_if.out_valid && u_if.out_ready) begin
        got = mk(u_if.out_reg, u_if.out_data, u_if.out_last);
        e = (sb.size() > 0) ? sb.pop_front() : mk(2'd0, 8'h00, 1'b0);
        n_vec++; if (got !== e) begin n_err++; $display("FAIL rst_ptr_beat got=%h want=%h", got, e); end
        beats++;
        avail = 4'b0000;
      end
    end
    n_vec++; if (beats != 1) begin n_err++; $display("FAIL rst_post_beats got=%0d want=1", beats); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_r4_priority();
    test_r3_pair();
    test_r3_withheld();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hp_drain_sched.md
Name: hp_drain_sched

Overview:
- Parasite-side scheduler for the four host-to-parasite byte FIFOs (R1-R4).
- Watches per-register data-available flags and arbitrates between them: R4 has fixed priority, R1-R3 are round-robin.
- For the winner it drives the register select, issues one read-enable pulse and captures the byte.
- It hands each byte downstream on a valid/ready stream tagged with its register number.
- R3 is handled specially: in two-byte mode it drains both bytes back-to-back as one atomic pair.

Parameters:
- SETTLE_CYCLES, 1: cycles the select is held before the read pulse, so the read mux settles; legal range 1-3.
- R4_PRIORITY, 1: 1 = R4 always wins over R1-R3; 0 = R4 joins the round-robin.

Ports:
- p_phi2  in  1  parasite clock; all state on the rising edge.
- p_rst  in  1  asynchronous, active-high reset.
- p_enable  in  4  per-register drain enable; bit n masks register n+1.
- p_data_available  in  4  per-register byte-available flags.
- p_r3_two_bytes_available  in  1  R3 holds at least 2 bytes.
- one_byte_mode  in  1  R3 single-byte mode.
- p_data  in  8  read data from the selected register.
- p_selectData  out  4  one-hot register select; 0 when idle.
- p_rdnw  out  1  1 = read; always 1 (no writes issued).
- p_rd_en  out  1  single-cycle read-enable pulse, fed to the FIFOs' p_phi2_en.
- out_valid  out  1  downstream byte valid.
- out_data  out  8  captured byte.
- out_reg  out  2  source register, 0=R1 .. 3=R4.
- out_last  out  1  last byte of a burst (always 1, except the first byte of an R3 pair).
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, p_rst=1) values:
  - Outputs: p_selectData=0, p_rd_en=0, p_rdnw=1, out_valid=0, out_data=0, out_reg=0, out_last=0, busy=0.
  - Internal: state=IDLE, round-robin pointer=R1.
- Reset mid-operation aborts immediately; a byte already popped but not accepted downstream is lost.
- Request vector: req[n] = p_data_available[n] & p_enable[n].
  - R3 exception: when one_byte_mode=0, req[2] also requires p_r3_two_bytes_available.
- IDLE:
  - If any req bit is set, grant one register and go to SELECT.
  - Grant rule: R4 first if R4_PRIORITY=1; otherwise the first requester at or after the round-robin pointer, wrapping R3->R1.
  - Pointer advances to grant+1 (mod 3) only when an R1-R3 grant completes.
- SELECT: p_selectData = one-hot grant for SETTLE_CYCLES cycles, then go to READ.
- READ (exactly one cycle):
  - p_rd_en=1; p_data is sampled into out_data in this cycle.
  - Next state is HOLD, with out_valid=1 and out_reg=grant.
  - p_selectData stays asserted through READ and drops entering HOLD.
- HOLD:
  - out_valid held, and out_data/out_reg stable, until out_ready=1.
  - On acceptance, the next state depends on the grant:
    - R3 pair with first byte done: go to SELECT for byte 2. No re-arbitration and no check of p_data_available: the pair was pre-qualified.
    - Otherwise: go to IDLE.
- out_last = 0 on the first byte of an R3 pair, 1 otherwise.
- Latency: request in cycle 0 -> grant registered cycle 1 -> p_rd_en in cycle 1+SETTLE_CYCLES -> out_valid the following cycle.
  - Minimum idle-to-idle time is SETTLE_CYCLES+3 cycles with out_ready tied high.
- Changes to p_enable or one_byte_mode while busy take effect at the next IDLE arbitration only.
- Dropping a request after grant is not re-checked: the read is still issued. The FIFO's empty-read behaviour applies.
- Never more than one p_rd_en per byte; p_rd_en is never asserted in IDLE, SELECT or HOLD.

Optional Feature:
- Macro: HP_DRAIN_STATS_EN.
- Defined:
  - Adds output drain_count (4x16, packed 64 bits): per-register counters that increment on each p_rd_en for that register.
  - Counters saturate at 0xFFFF and clear on p_rst.
  - Adds input stats_clr: clears all counters synchronously; the clear wins over a same-cycle increment.
- Undefined: port and logic absent; the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, SELECT, READ, HOLD);
  - register index constants R1_IDX..R4_IDX;
  - COUNT_W=16.
- One sub-module, hp_rr_arb3:
  - combinational 3-way round-robin picker;
  - inputs: req[2:0], ptr[1:0];
  - outputs: one-hot grant, grant valid.
  - R4 priority and the FSM stay in the top level.

Test Plan:
- Single request, SETTLE_CYCLES=1, out_ready=1:
  - Stimulus: p_data_available=0001, p_data=0x5A.
  - Response: p_selectData=0001 for 2 cycles; one p_rd_en; out_valid with out_data=0x5A, out_reg=0, out_last=1; busy drops after acceptance.
- R4 priority:
  - Stimulus: p_data_available=1111 held, R4_PRIORITY=1.
  - Response: out_reg order is 3,3,3 while R4 persists; after R4 clears, order is 0,1,2,0 (round-robin wrap).
- R3 pair:
  - Stimulus: one_byte_mode=0, p_data_available=0100, two_bytes_available=1, data 0x11 then 0x22.
  - Response: two beats, out_reg=2, out_last 0 then 1; no other register granted between them even if R1 raises after beat 1.
- R3 withheld:
  - Stimulus: one_byte_mode=0, two_bytes_available=0, p_data_available=0100.
  - Response: no grant or p_rd_en for 20 cycles; setting one_byte_mode=1 produces a single read.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles.
  - Response: out_valid and out_data stable; no further p_rd_en; acceptance on the 11th cycle.
- Reset mid-READ:
  - Stimulus: assert p_rst asynchronously during p_rd_en.
  - Response: all outputs go to reset values in the same cycle; the round-robin pointer returns to R1.
